// File: rtl/frontend_pkg.sv
// Shared fetch-stage types and constants for frontend_stage.
package frontend_pkg;

  typedef enum logic {
    FS_RUN        = 1'b0,
    FS_MISALIGNED = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry data+valid holding register with capture and clear (clear wins).
module fetch_skid_buf (
  input  logic        clk,
  input  logic        nrst,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        valid
);

  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;

  // Next-state: clear drops the entry, capture loads it.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      data_d  = din;
    end
  end

  // Entry register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/frontend_stage.sv
// Fetch stage: PC ownership, redirect priority, misaligned-target handling,
// wrong-path squash. Optional skid buffer enabled by macro FETCH_SKID_EN.
module frontend_stage
  import frontend_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = frontend_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        trap_redirect,
  input  logic [31:0] trap_pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc2,
  output logic [31:0] instr2,
  output logic        instruction_addr_misaligned2
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc1_q, pc1_d;
  logic [31:0]  pc2_q, pc2_d;
  logic         kill_q, kill_d;
  logic         mis2_q, mis2_d;
  logic         redirect_take;
  logic         unused_trap_lsb;

  assign unused_trap_lsb = ^trap_pc[1:0];

  // Branch redirects are ignored while frozen on a misaligned target; traps win.
  assign redirect_take = redirect && !trap_redirect && (state_q == FS_RUN);

  // Next-PC selection and squash/misalign bookkeeping.
  always_comb begin
    state_d = state_q;
    pc1_d   = pc1_q;
    pc2_d   = pc2_q;
    kill_d  = kill_q;
    mis2_d  = mis2_q;
    if (trap_redirect) begin
      pc1_d   = {trap_pc[31:2], 2'b00};
      pc2_d   = pc1_q;
      kill_d  = 1'b1;
      mis2_d  = 1'b0;
      state_d = FS_RUN;
    end else if (redirect_take) begin
      kill_d = 1'b1;
      pc1_d  = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        // Misaligned target goes straight to pc2 so the exception reports next cycle.
        pc2_d   = redirect_pc;
        mis2_d  = 1'b1;
        state_d = FS_MISALIGNED;
      end else begin
        pc2_d  = pc1_q;
        mis2_d = 1'b0;
      end
    end else if (stall) begin
      // hold everything
    end else if (state_q == FS_MISALIGNED) begin
      mis2_d = 1'b0;
    end else begin
      pc2_d  = pc1_q;
      pc1_d  = pc1_q + PC_STEP;
      kill_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= FS_RUN;
      pc1_q   <= RESET_PC;
      pc2_q   <= '0;
      kill_q  <= 1'b1;
      mis2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc1_q   <= pc1_d;
      pc2_q   <= pc2_d;
      kill_q  <= kill_d;
      mis2_q  <= mis2_d;
    end
  end

`ifdef FETCH_SKID_EN
  logic        skid_valid;
  logic [31:0] skid_data;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .nrst    (nrst),
    .capture (stall && !skid_valid),
    .clear   (!stall || trap_redirect || redirect_take),
    .din     (imem_rdata),
    .dout    (skid_data),
    .valid   (skid_valid)
  );

  assign imem_req  = (state_q == FS_RUN) && !stall;
  assign imem_addr = pc1_q;
  assign instr2    = kill_q ? NOP_INSTR : (skid_valid ? skid_data : imem_rdata);
`else
  assign imem_req  = (state_q == FS_RUN);
  // While stalled on a live word, re-address that word so the synchronous
  // memory keeps returning it; pc1 resumes on release with no lost fetch.
  assign imem_addr = (stall && !kill_q) ? pc2_q : pc1_q;
  assign instr2    = kill_q ? NOP_INSTR : imem_rdata;
`endif

  assign pc2                          = pc2_q;
  assign instruction_addr_misaligned2 = mis2_q;

endmodule

// File: tb/tb_frontend_stage.sv
// Self-checking bench for frontend_stage: directed table, reset-in-misaligned
// sequence, then randomized traffic against a reference model.
module tb_frontend_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        nrst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap_redirect;
  logic [31:0] trap_pc;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic [31:0] pc2;
  logic [31:0] instr2;
  logic        mis2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          fetched_200 = 1'b0;

  frontend_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk                          (clk),
    .nrst                         (nrst),
    .stall                        (stall),
    .redirect                     (redirect),
    .redirect_pc                  (redirect_pc),
    .trap_redirect                (trap_redirect),
    .trap_pc                      (trap_pc),
    .imem_addr                    (imem_addr),
    .imem_req                     (imem_req),
    .imem_rdata                   (imem_rdata),
    .pc2                          (pc2),
    .instr2                       (instr2),
    .instruction_addr_misaligned2 (mis2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory whose word equals its address.
  initial imem_rdata = '0;
  always @(posedge clk) begin
    if (imem_req) begin
      imem_rdata <= imem_addr;
      if (imem_addr == 32'h200) fetched_200 <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic exp_req(input logic frozen, input logic stl);
`ifdef FETCH_SKID_EN
    return !frozen && !stl;
`else
    return !frozen;
`endif
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic        stl;
    logic        rd;
    logic [31:0] rpc;
    logic        tr;
    logic [31:0] tpc;
    logic [31:0] e_pc2;
    logic [31:0] e_instr;
    logic        e_mis;
    logic        e_frozen;
  } row_t;

  row_t rows[28];

  function automatic row_t mk(input logic stl, input logic rd, input logic [31:0] rpc,
                              input logic tr, input logic [31:0] tpc,
                              input logic [31:0] e_pc2, input logic [31:0] e_instr,
                              input logic e_mis, input logic e_frozen);
    row_t r;
    r.stl = stl; r.rd = rd; r.rpc = rpc; r.tr = tr; r.tpc = tpc;
    r.e_pc2 = e_pc2; r.e_instr = e_instr; r.e_mis = e_mis; r.e_frozen = e_frozen;
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_fetch;   // address the fetch unit will request next
  logic [31:0] m_pc2;
  logic        m_bubble;
  logic        m_mis;
  logic        m_frozen;

  task automatic model_reset();
    m_fetch = 32'h0; m_pc2 = 32'h0; m_bubble = 1'b1; m_mis = 1'b0; m_frozen = 1'b0;
  endtask

  task automatic model_step(input logic stl, input logic rd, input logic [31:0] rpc,
                            input logic tr, input logic [31:0] tpc);
    if (tr) begin
      m_pc2 = m_fetch; m_fetch = tpc & ~32'd3;
      m_bubble = 1'b1; m_mis = 1'b0; m_frozen = 1'b0;
    end else if (rd && !m_frozen && (rpc % 4 != 0)) begin
      m_fetch = rpc; m_pc2 = rpc; m_bubble = 1'b1; m_mis = 1'b1; m_frozen = 1'b1;
    end else if (rd && !m_frozen) begin
      m_pc2 = m_fetch; m_fetch = rpc; m_bubble = 1'b1;
    end else if (!stl) begin
      if (m_frozen) m_mis = 1'b0;
      else begin
        m_pc2 = m_fetch; m_fetch = m_fetch + 4; m_bubble = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic stl, input logic rd, input logic [31:0] rpc,
                       input logic tr, input logic [31:0] tpc);
    stall = stl; redirect = rd; redirect_pc = rpc; trap_redirect = tr; trap_pc = tpc;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    nrst = 1'b0;
    repeat (3) @(negedge clk);

    // reset state observed during reset
    check("reset_imem_addr", imem_addr, 32'h0);
    check("reset_imem_req", {31'b0, imem_req}, 32'd1);
    check("reset_pc2", pc2, 32'h0);
    check("reset_instr2", instr2, NOP);
    check("reset_mis2", {31'b0, mis2}, 32'd0);

    rows[0]  = mk(0,0,0,0,0,                 32'h0,   NOP,     0,0);
    rows[1]  = mk(0,0,0,0,0,                 32'h0,   32'h0,   0,0);
    rows[2]  = mk(0,0,0,0,0,                 32'h4,   32'h4,   0,0);
    rows[3]  = mk(1,0,0,0,0,                 32'h8,   32'h8,   0,0);
    rows[4]  = mk(1,0,0,0,0,                 32'h8,   32'h8,   0,0);
    rows[5]  = mk(1,0,0,0,0,                 32'h8,   32'h8,   0,0);
    rows[6]  = mk(0,1,32'h100,0,0,           32'h8,   32'h8,   0,0);
    rows[7]  = mk(0,0,0,0,0,                 32'hc,   NOP,     0,0);
    rows[8]  = mk(0,0,0,0,0,                 32'h100, 32'h100, 0,0);
    rows[9]  = mk(0,0,0,0,0,                 32'h104, 32'h104, 0,0);
    rows[10] = mk(0,1,32'h102,0,0,           32'h108, 32'h108, 0,0);
    rows[11] = mk(0,0,0,0,0,                 32'h102, NOP,     1,1);
    rows[12] = mk(0,0,0,0,0,                 32'h102, NOP,     0,1);
    rows[13] = mk(0,1,32'h300,0,0,           32'h102, NOP,     0,1);
    rows[14] = mk(0,0,0,1,32'h80,            32'h102, NOP,     0,1);
    rows[15] = mk(0,0,0,0,0,                 32'h102, NOP,     0,0);
    rows[16] = mk(0,0,0,0,0,                 32'h80,  32'h80,  0,0);
    rows[17] = mk(0,1,32'h200,1,32'h83,      32'h84,  32'h84,  0,0);
    rows[18] = mk(0,0,0,0,0,                 32'h88,  NOP,     0,0);
    rows[19] = mk(0,0,0,0,0,                 32'h80,  32'h80,  0,0);
    rows[20] = mk(0,1,32'hffff_fffc,0,0,     32'h84,  32'h84,  0,0);
    rows[21] = mk(0,0,0,0,0,                 32'h88,  NOP,     0,0);
    rows[22] = mk(0,0,0,0,0,                 32'hffff_fffc, 32'hffff_fffc, 0,0);
    rows[23] = mk(0,0,0,0,0,                 32'h0,   32'h0,   0,0);
    rows[24] = mk(0,1,32'h206,0,0,           32'h4,   32'h4,   0,0);
    rows[25] = mk(1,0,0,0,0,                 32'h206, NOP,     1,1);
    rows[26] = mk(0,0,0,0,0,                 32'h206, NOP,     1,1);
    rows[27] = mk(0,0,0,0,0,                 32'h206, NOP,     0,1);

    nrst = 1'b1;
    for (int i = 0; i < 28; i++) begin
      drive(rows[i].stl, rows[i].rd, rows[i].rpc, rows[i].tr, rows[i].tpc);
      #1;
      check($sformatf("row%0d_pc2", i), pc2, rows[i].e_pc2);
      check($sformatf("row%0d_instr2", i), instr2, rows[i].e_instr);
      check($sformatf("row%0d_mis2", i), {31'b0, mis2}, {31'b0, rows[i].e_mis});
      check($sformatf("row%0d_req", i), {31'b0, imem_req},
            {31'b0, exp_req(rows[i].e_frozen, rows[i].stl)});
      @(posedge clk);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);
    check("never_fetched_0x200", {31'b0, fetched_200}, 32'd0);

    // Reset asserted while frozen on a misaligned target.
    nrst = 1'b0;
    #1;
    check("midrst_imem_addr", imem_addr, 32'h0);
    check("midrst_imem_req", {31'b0, imem_req}, 32'd1);
    check("midrst_pc2", pc2, 32'h0);
    check("midrst_mis2", {31'b0, mis2}, 32'd0);
    check("midrst_instr2", instr2, NOP);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check("postrst_c0_instr2", instr2, NOP);
    @(negedge clk);
    #1;
    check("postrst_c1_pc2", pc2, 32'h0);
    check("postrst_c1_instr2", instr2, 32'h0);
    @(negedge clk);
    #1;
    check("postrst_c2_pc2", pc2, 32'h4);

    // Randomized traffic against the reference model.
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic        s, r, t;
      logic [31:0] rp, tp;
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 9) == 0);
      t  = m_frozen ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      rp = ($urandom & 32'h0000_0ffc) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      tp = $urandom & 32'h0000_0fff;
      drive(s, r, rp, t, tp);
      #1;
      check("rnd_pc2", pc2, m_pc2);
      check("rnd_instr2", instr2, m_bubble ? NOP : m_pc2);
      check("rnd_mis2", {31'b0, mis2}, {31'b0, m_mis});
      check("rnd_req", {31'b0, imem_req}, {31'b0, exp_req(m_frozen, s)});
      if (!s) check("rnd_imem_addr", imem_addr, m_fetch);
      @(posedge clk);
      model_step(s, r, rp, t, tp);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frontend_stage.md
# frontend_stage

Pipeline stage 1–2 (fetch): owns the program counter, drives the synchronous instruction memory, and presents `pc2`/`instr2`/`instruction_addr_misaligned2` to the decode stage. It applies redirects in priority order: commit-stage traps and returns, then execute-stage branches and jumps, then decode stalls. It detects misaligned fetch targets and, on any redirect, squashes the wrong-path word by substituting a NOP.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `NOP_INSTR`, default `32'h0000_0013` (`addi x0,x0,0`): bubble encoding.

Ports:
- `clk`  in  1  clock. One clock; all state on its rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  decode/scoreboard stall; hold `pc2`/`instr2`.
- `redirect`  in  1  execute: taken branch or jump.
- `redirect_pc`  in  32  execute branch/jump target.
- `trap_redirect`  in  1  commit: exception entry or xRET.
- `trap_pc`  in  32  trap vector or return PC.
- `imem_addr`  out  32  fetch address (`pc1` register).
- `imem_req`  out  1  fetch request.
- `imem_rdata`  in  32  word for the address requested in the previous cycle.
- `pc2`  out  32  PC of the word on `instr2`.
- `instr2`  out  32  fetched instruction, or `NOP_INSTR`.
- `instruction_addr_misaligned2`  out  1  fetch exception for `pc2`.

## Operation
- State: `pc1`, `pc2`, `kill`, `mis2`, and FSM {`FS_RUN`, `FS_MISALIGNED`}.
- Next-PC priority:
  - `trap_redirect` loads `{trap_pc[31:2],2'b00}`.
  - else `redirect` (ignored in `FS_MISALIGNED`) loads `redirect_pc`.
  - else `stall` holds.
  - else loads `pc1+4`, wrapping modulo 2^32.
- Redirects override `stall`.
- Sequential advance: `pc2<=pc1`, `pc1<=pc1+4`.
- `instr2 = kill ? NOP_INSTR : imem_rdata`.
- Any redirect sets `kill` for the next cycle, so the in-flight wrong-path word becomes NOP. `kill` clears on the next non-stalled advance.
- `redirect_pc[1:0]!=0`:
  - `pc1<=redirect_pc`, FSM to `FS_MISALIGNED`, `imem_req=0`.
  - Next cycle: `pc2=redirect_pc`, `instr2=NOP_INSTR`, `mis2=1`.
  - `mis2` is high for exactly one non-stalled cycle; it is held while `stall`.
  - Then `pc1`/`pc2` freeze and NOPs are emitted until `trap_redirect` returns the FSM to `FS_RUN`.
- `imem_req=1` in `FS_RUN` (modified only by `FETCH_SKID_EN`).

## Timing
- Reset values:
  - `pc1=RESET_PC`, so `imem_addr=RESET_PC` and `imem_req=1` during reset.
  - `pc2=0`, `kill=1` (`instr2=NOP_INSTR`), `mis2=0`, FSM `FS_RUN`.
- Fetch latency: address in cycle n, word on `instr2` in cycle n+1 with `pc2` equal to that address.
- Branch/trap redirect penalty: exactly one NOP bubble. Target appears on `pc2` two cycles after the redirect cycle.
- Stall:
  - `pc1`, `pc2`, `kill`, `mis2` hold.
  - `imem_addr` is constant, so memory re-reads the same word and `instr2` stays stable.
- `trap_redirect` and `redirect` in the same cycle: trap wins.
- Reset asserted mid-operation: immediate return to the reset values; pending `kill`/`FS_MISALIGNED` are discarded.

## Configuration
- `FETCH_SKID_EN` defined:
  - `imem_req=0` while `stall`.
  - The word on `imem_rdata` in the first stall cycle is captured in a 1-entry skid buffer; `instr2` comes from the buffer while it is valid.
  - On the release cycle, `imem_req=1` re-requests `pc1`; the buffer clears at the advancing edge.
  - No added bubble.
- Undefined: no buffer; `imem_req` stays 1 during stall.
- `pc2`/`instr2` sequences are identical in both builds.

## Structure
- Shared package `frontend_pkg`:
  - `fetch_state_t` enum {`FS_RUN`, `FS_MISALIGNED`}.
  - `NOP_INSTR` constant.
  - `PC_STEP=4`.
- Sub-module `fetch_skid_buf`: 1-entry data+valid register with capture/clear, instantiated only under `FETCH_SKID_EN`.

## Test plan
- Reset release, `RESET_PC=0`, memory word = address:
  - `pc2`: 0,4,8,12 on consecutive cycles.
  - `instr2` matches; first cycle after reset is NOP.
- Stall for 3 cycles at `pc2=8`:
  - `pc2`/`instr2` hold 8/8.
  - Resume gives 12, no duplicate or lost word.
  - With `FETCH_SKID_EN`, `imem_req=0` during the stall.
- `redirect=1`, `redirect_pc=0x100` while `pc2=8` → next cycle `instr2=NOP`; the cycle after, `pc2=0x100`; then 0x104.
- `redirect_pc=0x102`:
  - One cycle `pc2=0x102`, `mis2=1`, `instr2=NOP`.
  - Then NOPs with `imem_req=0`.
  - `trap_redirect` to 0x80 gives bubble, then `pc2=0x80`.
- `trap_redirect` (`trap_pc=0x80`) and `redirect` (0x200) in the same cycle → `pc2=0x80`; 0x200 is never fetched.
- `nrst` low mid-stream in `FS_MISALIGNED` → immediately `imem_addr=RESET_PC`, `pc2=0`, `mis2=0`, `instr2=NOP`.
